lu_pipe_acc: RTL and testbench



---
 rtl/lu_pipe_acc_if.sv | 38 +++
 rtl/lu_pipe_acc.sv | 112 +++++++++++
 tb/tb_lu_pipe_acc.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lu_pipe_acc_if.sv
// lu_pipe_acc_if: operand/result bus of the lu_pipe_acc logic unit.
//   master : operand source and result consumer (drives operands, out_ready)
//   slave  : the logic unit (drives in_ready, result, flags, op_count)
// Signals:
//   in_valid/in_ready   operand handshake
//   a, b, select_op     operands and operation code
//   use_acc, acc_clear  accumulator operand select / synchronous clear
//   out_valid/out_ready result handshake
//   s_out, zero, parity registered result and its flags
//   op_count            accepted-operation counter
interface lu_pipe_acc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       select_op;
  logic             use_acc;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s_out;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, select_op, use_acc, acc_clear, out_ready,
    input  in_ready, out_valid, s_out, zero, parity, op_count
  );

  modport slave (
    input  in_valid, a, b, select_op, use_acc, acc_clear, out_ready,
    output in_ready, out_valid, s_out, zero, parity, op_count
  );
endinterface

// File: rtl/lu_pipe_acc.sv
// lu_pipe_acc: WIDTH-bit eight-operation logic unit with one register stage,
// an accumulator that can replace operand B, result flags and a counter of
// accepted operations.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears every register
//   bus  lu_pipe_acc_if slave modport (operands, handshakes, result, flags)
//
// Handshake: a transfer happens on an edge where valid & ready are both 1.
// in_ready = !out_valid | out_ready and never depends on in_valid. While
// out_valid=1 and out_ready=0 the result, flags and out_valid hold, and any
// operands presented are left unconsumed. A new accept while the old result
// is taken overwrites the register on the same edge (no bubble).
module lu_pipe_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  lu_pipe_acc_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NAND = 3'b000,
    OP_AND  = 3'b001,
    OP_NOR  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] s_q;
  logic             zero_q;
  logic             parity_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             in_ready;
  logic             accept;

  assign in_ready  = !out_valid_q | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  // The operand is the accumulator value from before this edge, even when
  // the same edge writes back or clears it.
  assign operand_b = bus.use_acc ? acc_q : bus.b;

  always_comb begin
    result = '0;
    case (op_e'(bus.select_op))
      OP_NAND: result = ~(bus.a & operand_b);
      OP_AND:  result = bus.a & operand_b;
      OP_NOR:  result = ~(bus.a | operand_b);
      OP_OR:   result = bus.a | operand_b;
      OP_XOR:  result = bus.a ^ operand_b;
      OP_XNOR: result = ~(bus.a ^ operand_b);
      OP_NOTA: result = ~bus.a;
      OP_PASS: result = bus.a;
      default: result = '0;
    endcase
  end

  // Result register with its flags and the output valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      s_q         <= result;
      zero_q      <= (result == '0);
      parity_q    <= ^result;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      // Drain: s_out keeps its last value, only valid drops.
      out_valid_q <= 1'b0;
    end
  end

  // acc_clear is looked at every edge and overrides the accept write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (bus.acc_clear) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= result;
    end
  end

  // Accepted-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.s_out     = s_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_lu_pipe_acc.sv
// tb_lu_pipe_acc: drives an 8-bit/8-bit-count unit and a 1-bit/2-bit-count
// unit with the same stimulus (the 1-bit unit sees bit 0 of every operand).
// Because all operations are bitwise, the 1-bit expectations are bit 0 of
// the 8-bit expectations, and its counter is the 8-bit count modulo 4.
module tb_lu_pipe_acc;

  logic clk;
  logic rst;

  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] select_op;
  logic       use_acc;
  logic       acc_clear;
  logic       out_ready;

  lu_pipe_acc_if #(.WIDTH(8), .CNT_W(8)) bus  ();
  lu_pipe_acc_if #(.WIDTH(1), .CNT_W(2)) sbus ();

  assign bus.in_valid   = in_valid;
  assign bus.a          = a;
  assign bus.b          = b;
  assign bus.select_op  = select_op;
  assign bus.use_acc    = use_acc;
  assign bus.acc_clear  = acc_clear;
  assign bus.out_ready  = out_ready;

  assign sbus.in_valid  = in_valid;
  assign sbus.a         = a[0];
  assign sbus.b         = b[0];
  assign sbus.select_op = select_op;
  assign sbus.use_acc   = use_acc;
  assign sbus.acc_clear = acc_clear;
  assign sbus.out_ready = out_ready;

  lu_pipe_acc #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  lu_pipe_acc #(.WIDTH(1), .CNT_W(2)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  logic [7:0] exp_q[$];
  logic       m_ov;
  logic [7:0] m_acc;
  logic [7:0] m_count;
  logic [7:0] m_last;
  int         checks;
  int         errors;

  function automatic logic [7:0] model_op(input logic [2:0] op,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
    case (op)
      3'd0:    return ~(x & y);
      3'd1:    return x & y;
      3'd2:    return ~(x | y);
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov    = 1'b0;
    m_acc   = '0;
    m_count = '0;
    m_last  = '0;
    exp_q.delete();
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic ua, input logic ac,
                        input logic ordy);
    in_valid  = v;
    select_op = op;
    a         = av;
    b         = bv;
    use_acc   = ua;
    acc_clear = ac;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    model_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_s_out", bus.s_out, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_parity", bus.parity, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_w1_out_valid", sbus.out_valid, 0);
    check("rst_w1_op_count", sbus.op_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock with the inputs currently driven: check in_ready, predict the
  // accept, push the expected result, cross the edge, then check outputs.
  task automatic step(input string tag);
    logic       acc_now;
    logic [7:0] res;
    #2;
    check({tag, "_in_ready"}, bus.in_ready, !m_ov | out_ready);
    check({tag, "_w1_in_ready"}, sbus.in_ready, !m_ov | out_ready);
    acc_now = in_valid & (!m_ov | out_ready);
    res = model_op(select_op, a, use_acc ? m_acc : b);
    if (acc_now) exp_q.push_back(res);
    if (acc_now) begin
      m_ov    = 1'b1;
      m_count = m_count + 8'd1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (acc_clear) m_acc = '0;
    else if (acc_now) m_acc = res;
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, bus.out_valid, m_ov);
    check({tag, "_op_count"}, bus.op_count, m_count);
    check({tag, "_w1_out_valid"}, sbus.out_valid, m_ov);
    check({tag, "_w1_op_count"}, sbus.op_count, m_count[1:0]);
    if (acc_now && exp_q.size() != 0) m_last = exp_q.pop_front();
    if (m_ov) begin
      check({tag, "_s_out"}, bus.s_out, m_last);
      check({tag, "_zero"}, bus.zero, m_last == 8'h00);
      check({tag, "_parity"}, bus.parity, ^m_last);
      check({tag, "_w1_s_out"}, sbus.s_out, m_last[0]);
      check({tag, "_w1_zero"}, sbus.zero, !m_last[0]);
      check({tag, "_w1_parity"}, sbus.parity, m_last[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;

    // 1. Legacy table: a=0, b=1, ops 000/001/011/010
    do_reset();
    set_in(1'b1, 3'b000, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1); step("leg_nand");
    set_in(1'b1, 3'b001, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1); step("leg_and");
    set_in(1'b1, 3'b011, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1); step("leg_or");
    set_in(1'b1, 3'b010, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1); step("leg_nor");
    set_in(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1); step("leg_drain");
    check("leg_count4", bus.op_count, 4);

    // 2. All eight operations back to back on C3/A5
    for (int op = 0; op < 8; op++) begin
      set_in(1'b1, 3'(op), 8'hC3, 8'hA5, 1'b0, 1'b0, 1'b1);
      step($sformatf("op%0d", op));
    end
    set_in(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1); step("ops_drain");

    // 3. Backpressure: result held, new operands not consumed
    set_in(1'b1, 3'b001, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1); step("bp_accept");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 3'b100, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      step($sformatf("bp_hold%0d", i));
    end
    set_in(1'b1, 3'b100, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1); step("bp_release");
    set_in(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1); step("bp_drain");

    // 4. Accumulator chain with a concurrent clear
    set_in(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1); step("acc_clr");
    set_in(1'b1, 3'b011, 8'h01, 8'hAA, 1'b1, 1'b0, 1'b1); step("acc_1");
    set_in(1'b1, 3'b011, 8'h02, 8'hAA, 1'b1, 1'b0, 1'b1); step("acc_2");
    set_in(1'b1, 3'b011, 8'h04, 8'hAA, 1'b1, 1'b0, 1'b1); step("acc_3");
    set_in(1'b1, 3'b011, 8'h08, 8'hAA, 1'b1, 1'b1, 1'b1); step("acc_4_clr");
    set_in(1'b1, 3'b011, 8'h10, 8'hAA, 1'b1, 1'b0, 1'b1); step("acc_5");
    set_in(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1); step("acc_drain");

    // 5. Zero flag and counter wrap on the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 3'b001, 8'h00, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
      step($sformatf("wrap%0d", i));
    end

    // Random back-to-back traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)));
      step($sformatf("rnd%0d", i));
    end

    // 6. Asynchronous reset while a result is stalled
    set_in(1'b1, 3'b111, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0); step("ar_load");
    set_in(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("ar_out_valid", bus.out_valid, 0);
    check("ar_s_out", bus.s_out, 0);
    check("ar_acc", u_dut.acc_q, 0);
    check("ar_op_count", bus.op_count, 0);
    check("ar_in_ready", bus.in_ready, 1);
    check("ar_w1_out_valid", sbus.out_valid, 0);
    check("ar_w1_op_count", sbus.op_count, 0);
    #2;
    rst = 1'b0;
    model_reset();
    set_in(1'b1, 3'b011, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1); step("ar_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
